// File: rtl/kmeans_call_sched_if.sv
// Bundles the requester-facing and component-facing buses of the kmeans call scheduler.
// The scheduler uses the slave view; requesters and the kmeans component sit on the master view.
interface kmeans_call_sched_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ*32-1:0] req_idx;
   logic [N_REQ*32-1:0] req_num_clusters;
   logic [N_REQ*32-1:0] req_num_dim;
   logic [N_REQ-1:0]    rsp_valid;
   logic [N_REQ-1:0]    rsp_ready;
   logic [31:0]         rsp_data;
   logic                k_start;
   logic                k_busy;
   logic [31:0]         k_idx;
   logic [31:0]         k_num_clusters;
   logic [31:0]         k_num_dim;
   logic                k_done;
   logic                k_stall;
   logic [31:0]         k_returndata;

   modport slave (
      input  req_valid, req_idx, req_num_clusters, req_num_dim, rsp_ready,
      input  k_busy, k_done, k_returndata,
      output req_ready, rsp_valid, rsp_data,
      output k_start, k_idx, k_num_clusters, k_num_dim, k_stall
   );

   modport master (
      output req_valid, req_idx, req_num_clusters, req_num_dim, rsp_ready,
      output k_busy, k_done, k_returndata,
      input  req_ready, rsp_valid, rsp_data,
      input  k_start, k_idx, k_num_clusters, k_num_dim, k_stall
   );
endinterface

// File: rtl/kmeans_call_sched.sv
// Round-robin shares one kmeans component among N_REQ requesters; grant to k_start is one cycle,
// the call slot holds while k_busy, and returns follow call order with k_stall driven by the owner's rsp_ready.
module kmeans_call_sched #(
   parameter int N_REQ   = 4,
   parameter int MAX_OUT = 8,
   parameter int TAG_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   parameter int CNT_W   = $clog2(MAX_OUT) + 1
) (
   input  logic             clock,
   input  logic             resetn,
   kmeans_call_sched_if.slave bus,
   output logic [CNT_W-1:0] outstanding,
   output logic             err_unexpected
);
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] num_clusters;
      logic [31:0] num_dim;
   } args_t;

   args_t            slot_args;
   args_t            win_args;
   logic             slot_vld;
   logic [TAG_W-1:0] rr_ptr;
   logic [TAG_W-1:0] winner;
   logic [TAG_W:0]   cand;
   logic             found;
   logic [TAG_W-1:0] tag_mem [MAX_OUT];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [TAG_W-1:0] head;
   logic             fifo_empty;
   logic             full;
   logic             accept;
   logic             load;
   logic             pop;

   // Scan from rr_ptr upward with wraparound; the first active request wins.
   always_comb begin
      winner = rr_ptr;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (TAG_W+1)'(k);
         if (cand >= (TAG_W+1)'(N_REQ)) begin
            cand = cand - (TAG_W+1)'(N_REQ);
         end
         if (!found && bus.req_valid[cand[TAG_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[TAG_W-1:0];
         end
      end
   end

   always_comb begin
      win_args = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winner == TAG_W'(i)) begin
            win_args.idx          = bus.req_idx[32*i +: 32];
            win_args.num_clusters = bus.req_num_clusters[32*i +: 32];
            win_args.num_dim      = bus.req_num_dim[32*i +: 32];
         end
      end
   end

   // Full is judged on the registered count, so a return in the same cycle cannot open a slot.
   assign accept     = slot_vld & ~bus.k_busy;
   assign full       = (outstanding == CNT_W'(MAX_OUT));
   assign fifo_empty = (outstanding == '0);
   assign load       = (~slot_vld | accept) & ~full & found;
   assign head       = tag_mem[rd_ptr];
   assign pop        = bus.k_done & ~fifo_empty & bus.rsp_ready[head];

   always_comb begin
      bus.req_ready = '0;
      if (load) begin
         bus.req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      bus.rsp_valid = '0;
      bus.k_stall   = 1'b1;
      if (!fifo_empty) begin
         bus.rsp_valid[head] = bus.k_done;
         bus.k_stall         = ~bus.rsp_ready[head];
      end
   end

   assign bus.rsp_data       = bus.k_returndata;
   assign bus.k_start        = slot_vld;
   assign bus.k_idx          = slot_args.idx;
   assign bus.k_num_clusters = slot_args.num_clusters;
   assign bus.k_num_dim      = slot_args.num_dim;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         slot_vld       <= 1'b0;
         slot_args      <= '0;
         rr_ptr         <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         outstanding    <= '0;
         err_unexpected <= 1'b0;
      end else begin
         if (load) begin
            slot_vld  <= 1'b1;
            slot_args <= win_args;
            rr_ptr    <= (winner == TAG_W'(N_REQ-1)) ? '0 : winner + 1'b1;
            wr_ptr    <= wr_ptr + 1'b1;
         end else if (accept) begin
            slot_vld <= 1'b0;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({load, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (bus.k_done && fifo_empty) begin
            err_unexpected <= 1'b1;
         end
      end
   end

   // Tag storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clock) begin
      if (load) begin
         tag_mem[wr_ptr] <= winner;
      end
   end
endmodule

// File: tb/tb_kmeans_call_sched.sv
// Directed bench for kmeans_call_sched: arbitration, call/return backpressure, full limit, error and async reset.
module tb_kmeans_call_sched;
   logic       clock;
   logic       resetn;
   logic [3:0] outstanding;
   logic       err_unexpected;
   int         checks;
   int         failures;
   int         grants;

   kmeans_call_sched_if #(.N_REQ(4)) bus ();

   kmeans_call_sched #(.N_REQ(4), .MAX_OUT(8)) dut (
      .clock          (clock),
      .resetn         (resetn),
      .bus            (bus.slave),
      .outstanding    (outstanding),
      .err_unexpected (err_unexpected)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_args(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      bus.req_idx[32*i +: 32]          = a;
      bus.req_num_clusters[32*i +: 32] = b;
      bus.req_num_dim[32*i +: 32]      = c;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      grants = 0;
      resetn = 1'b0;
      bus.req_valid = '0;
      bus.req_idx = '0;
      bus.req_num_clusters = '0;
      bus.req_num_dim = '0;
      bus.rsp_ready = '0;
      bus.k_busy = 1'b0;
      bus.k_done = 1'b0;
      bus.k_returndata = '0;
      #2;
      chk("rst_k_start", bus.k_start, 0);
      chk("rst_k_stall", bus.k_stall, 1);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err_unexpected, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_k_idx", bus.k_idx, 0);
      tick();
      tick();
      resetn = 1'b1;

      // Single call
      set_args(0, 5, 3, 2);
      bus.req_valid = 4'b0001;
      #1;
      chk("single_grant", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid = '0;
      #1;
      chk("single_k_start", bus.k_start, 1);
      chk("single_args", {bus.k_idx[15:0], bus.k_num_clusters[15:0], bus.k_num_dim[15:0]}, 48'h0005_0003_0002);
      chk("single_out1", outstanding, 1);
      chk("single_no_grant", bus.req_ready, 0);
      tick();
      chk("single_start_clear", bus.k_start, 0);
      bus.k_done = 1'b1;
      bus.k_returndata = 32'h2A;
      bus.rsp_ready = 4'b1111;
      #1;
      chk("single_rsp_valid", bus.rsp_valid, 4'b0001);
      chk("single_rsp_data", bus.rsp_data, 32'h2A);
      chk("single_k_stall", bus.k_stall, 0);
      tick();
      bus.k_done = 1'b0;
      chk("single_out0", outstanding, 0);

      // Round robin from a fresh pointer
      do_reset();
      for (int i = 0; i < 4; i++) set_args(i, 10 + i, 20 + i, 30 + i);
      bus.req_valid = 4'b1111;
      for (int g = 0; g < 6; g++) begin
         #1;
         chk("rr_grant", bus.req_ready, 4'b0001 << (g % 4));
         tick();
         chk("rr_k_idx", bus.k_idx, 10 + (g % 4));
      end
      bus.req_valid = '0;
      #1;
      chk("rr_out6", outstanding, 6);
      bus.k_done = 1'b1;
      for (int r = 0; r < 6; r++) begin
         bus.k_returndata = 32'h100 + r;
         #1;
         chk("rr_rsp_valid", bus.rsp_valid, 4'b0001 << (r % 4));
         chk("rr_rsp_data", bus.rsp_data, 32'h100 + r);
         tick();
      end
      bus.k_done = 1'b0;
      chk("rr_out0", outstanding, 0);

      // Call backpressure: rr pointer now at 2
      bus.k_busy = 1'b1;
      set_args(2, 12, 22, 32);
      bus.req_valid = 4'b0100;
      #1;
      chk("bp_grant", bus.req_ready, 4'b0100);
      tick();
      set_args(2, 32'h77, 22, 32);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("bp_k_start", bus.k_start, 1);
         chk("bp_k_idx_hold", bus.k_idx, 12);
         chk("bp_no_grant", bus.req_ready, 0);
         tick();
      end
      bus.k_busy = 1'b0;
      #1;
      chk("bp_accept_grant", bus.req_ready, 4'b0100);
      tick();
      bus.req_valid = '0;
      chk("bp_next_idx", bus.k_idx, 32'h77);
      tick();
      chk("bp_start_clear", bus.k_start, 0);
      chk("bp_out2", outstanding, 2);
      bus.k_done = 1'b1;
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 4'b0100);
      tick();
      tick();
      bus.k_done = 1'b0;
      chk("bp_out0", outstanding, 0);

      // Full limit: rr pointer now at 3
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (bus.req_ready != 0) grants++;
         tick();
      end
      chk("full_grants", grants, 8);
      chk("full_out8", outstanding, 8);
      chk("full_no_grant", bus.req_ready, 0);
      bus.k_done = 1'b1;
      #1;
      chk("full_pop_rsp", bus.rsp_valid, 4'b1000);
      chk("full_pop_no_grant", bus.req_ready, 0);
      tick();
      bus.k_done = 1'b0;
      #1;
      chk("full_out7", outstanding, 7);
      chk("full_next_grant", bus.req_ready, 4'b1000);
      tick();
      bus.req_valid = '0;
      chk("full_out8_again", outstanding, 8);

      // Return backpressure: pop tags 0,1 then stall on head tag 2
      bus.k_done = 1'b1;
      tick();
      tick();
      bus.rsp_ready = 4'b1011;
      bus.k_returndata = 32'h55;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("rbp_k_stall", bus.k_stall, 1);
         chk("rbp_rsp_valid", bus.rsp_valid, 4'b0100);
         chk("rbp_rsp_data", bus.rsp_data, 32'h55);
         chk("rbp_out6", outstanding, 6);
         tick();
      end
      bus.rsp_ready = 4'b1111;
      #1;
      chk("rbp_release", bus.k_stall, 0);
      tick();
      bus.k_done = 1'b0;
      chk("rbp_out5", outstanding, 5);

      // Unexpected return, then async reset with 3 outstanding
      do_reset();
      bus.k_done = 1'b1;
      #1;
      chk("err_no_rsp", bus.rsp_valid, 0);
      chk("err_stall", bus.k_stall, 1);
      chk("err_before_edge", err_unexpected, 0);
      tick();
      bus.k_done = 1'b0;
      chk("err_set", err_unexpected, 1);
      tick();
      chk("err_sticky", err_unexpected, 1);
      chk("err_out0", outstanding, 0);
      bus.req_valid = 4'b0111;
      tick();
      tick();
      tick();
      bus.req_valid = '0;
      bus.k_busy = 1'b1;
      #1;
      chk("mid_out3", outstanding, 3);
      chk("mid_k_start", bus.k_start, 1);
      resetn = 1'b0;
      #1;
      chk("arst_out0", outstanding, 0);
      chk("arst_k_start", bus.k_start, 0);
      chk("arst_err", err_unexpected, 0);
      chk("arst_k_stall", bus.k_stall, 1);
      tick();
      resetn = 1'b1;
      bus.k_busy = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/kmeans_call_sched.md
Name: kmeans_call_sched

Overview:
- Shares one kmeans HLS component between N_REQ requesters.
- Round-robin arbitrates call requests and drives the component call interface (start/busy plus argument buses).
- Tracks up to MAX_OUT in-flight calls in an in-order tag FIFO.
- Steers each return value back to the requester that issued the call.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- MAX_OUT, 8: maximum calls issued but not yet returned; tag FIFO depth (power of 2).
- TAG_W, clog2(N_REQ): derived; width of requester index.

Ports:
- clock  in  1  single clock domain.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester call request.
- req_ready  out  N_REQ  per-requester call accepted this cycle.
- req_idx  in  N_REQ*32  idx argument, requester i at bits [32i+31:32i].
- req_num_clusters  in  N_REQ*32  num_clusters argument, same packing.
- req_num_dim  in  N_REQ*32  num_dim argument, same packing.
- rsp_valid  out  N_REQ  return data valid for requester i.
- rsp_ready  in  N_REQ  requester i accepts the return.
- rsp_data  out  32  return value, broadcast to all requesters.
- k_start  out  1  component call.valid.
- k_busy  in  1  component call stall.
- k_idx, k_num_clusters, k_num_dim  out  32 each  component arguments.
- k_done  in  1  component return.valid.
- k_stall  out  1  component return stall.
- k_returndata  in  32  component returndata.
- outstanding  out  clog2(MAX_OUT)+1  number of calls loaded and not yet returned.
- err_unexpected  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, resetn=0):
  - k_start=0, argument registers=0, req_ready=0, rsp_valid=0.
  - k_stall=1, outstanding=0, err_unexpected=0.
  - rr_ptr=0, tag FIFO empty.
  - Reset mid-operation discards all in-flight calls and tags. The component shares resetn.
- Call stage:
  - One registered slot: k_start plus the three argument registers.
  - The component accepts a call when k_start=1 and k_busy=0.
  - While k_start=1 and k_busy=1, k_start and all arguments hold stable.
- Load condition, all of:
  - the slot is empty or is being accepted this cycle;
  - outstanding < MAX_OUT;
  - some req_valid bit is 1.
- Arbitration:
  - Winner w = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - On load: req_ready[w]=1 combinationally in that cycle (one-hot or zero). The slot captures w's arguments at the next edge and w is pushed into the tag FIFO. rr_ptr <= (w+1) mod N_REQ.
  - Without a load, rr_ptr holds.
- Throughput: back-to-back loads are possible every cycle when k_busy=0.
- Call latency: req handshake at edge n gives k_start=1 from cycle n+1.
- outstanding:
  - Increments on load, decrements on return handshake.
  - Both in the same cycle leaves it unchanged.
  - The count includes a call still waiting in the slot.
- Return path (combinational, returns are in call order):
  - t = FIFO head.
  - If the FIFO is non-empty: rsp_valid[t] = k_done, rsp_data = k_returndata, k_stall = ~rsp_ready[t].
  - If the FIFO is empty: k_stall=1 and all rsp_valid=0.
  - Return handshake when k_done=1 and k_stall=0: pop the FIFO.
  - The return-path output is independent of req_ready.
- Error: k_done=1 while the FIFO is empty sets err_unexpected=1, which holds until reset. That return is neither popped nor delivered.
- Full: when outstanding=MAX_OUT, no req_ready is asserted. A pop that cycle does not permit a load in the same cycle; the load happens on the next cycle. This keeps the FIFO free of simultaneous push-on-full.
- Simultaneous push and pop on the tag FIFO (non-empty, not full) is legal. Its occupancy stays unchanged.

Test Plan:
- Single call: req_valid=0001, idx=5, num_clusters=3, num_dim=2, k_busy=0 → req_ready[0]=1 for one cycle; k_start=1 next cycle with args 5/3/2. k_done with returndata=0x2A → rsp_valid=0001, rsp_data=0x2A, outstanding 1→0.
- Round-robin fairness: req_valid=1111 held, k_busy=0 → grant order 0,1,2,3,0,1. Returns in order are routed to rsp_valid 0001,0010,0100,1000.
- Call backpressure: k_busy=1 for 4 cycles after k_start → k_start and args stable for all 4 cycles; no new req_ready while the slot is full; accepted on the first k_busy=0 cycle.
- Full limit: MAX_OUT=8, component never returns → exactly 8 grants, then req_ready stays 0 and outstanding=8. One return → the next grant occurs one cycle later.
- Return backpressure: k_done=1, head tag=2, rsp_ready[2]=0 for 3 cycles → k_stall=1 and rsp_valid[2]=1 held with stable data; pop occurs in the cycle rsp_ready[2]=1.
- Error and reset: k_done=1 with no calls → err_unexpected=1, sticky. Then resetn=0 mid-traffic with 3 outstanding → outstanding=0, k_start=0, err_unexpected=0 immediately, before any clock edge.
